// File: rtl/dsp_seq_pkg.sv
// Shared types and OPMODE encodings for the DSP48A1 MAC sequencer.
package dsp_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StRun,
    StDrain,
    StDone
  } state_e;

  // OPMODE fields: [1:0] X mux, [3:2] Z mux.
  localparam logic [7:0] OPM_IDLE = 8'h00;
  localparam logic [7:0] OPM_MUL  = 8'h01;
  localparam logic [7:0] OPM_MAC  = 8'h09;

endpackage

// File: rtl/dsp_opm_delay.sv
// OPMODE delay line that advances with the slice clock enable so the mode
// arrives at the post-adder together with its beat.
module dsp_opm_delay #(
  parameter int unsigned Depth = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [7:0] opm_i,
  output logic [7:0] opm_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, en_i, clr_i};
    assign opm_o = opm_i;
  end else begin : g_shift
    logic [7:0] sr_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(Depth); i++) sr_q[i] <= '0;
      end else if (clr_i) begin
        for (int i = 0; i < int'(Depth); i++) sr_q[i] <= '0;
      end else if (en_i) begin
        sr_q[0] <= opm_i;
        for (int i = 1; i < int'(Depth); i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign opm_o = sr_q[Depth-1];
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1-style slice through an N-beat multiply-accumulate job:
// streams operand pairs, drives OPMODE/CE/RSTP and pulses done once P settles.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int unsigned A_W     = 18,
  parameter int unsigned B_W     = 18,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned LAT     = 4,
  parameter int unsigned OPM_DLY = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a_in,
  input  logic [B_W-1:0]   b_in,
  output logic [A_W-1:0]   dsp_a,
  output logic [B_W-1:0]   dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rstp
);

  localparam int unsigned DW = $clog2(LAT);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             first_q, first_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [7:0]       opm_issue;
  logic             kill;

  assign kill = abort && (state_q != StIdle);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      first_q     <= 1'b0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      drain_q     <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    drain_d     = drain_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            remaining_d = len;
            first_d     = 1'b1;
            state_d     = StRun;
          end else begin
            state_d = StClr;
          end
        end
      end
      StClr: state_d = StDone;
      StRun: begin
        if (in_valid) begin
          remaining_d = remaining_q - LEN_W'(1);
          first_d     = 1'b0;
          if (remaining_q == LEN_W'(1)) begin
            drain_d = DW'(LAT - 1);
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        drain_d = drain_q - DW'(1);
        if (drain_q == DW'(1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort wins over every transition, including the last-beat handshake.
    if (kill) begin
      state_d     = StIdle;
      remaining_d = '0;
      first_d     = 1'b0;
      drain_d     = '0;
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone) && !abort;
    in_ready  = 1'b0;
    dsp_ce    = 1'b0;
    dsp_rstp  = 1'b0;
    dsp_a     = '0;
    dsp_b     = '0;
    opm_issue = OPM_IDLE;
    case (state_q)
      StClr: dsp_rstp = 1'b1;
      StRun: begin
        in_ready  = 1'b1;
        dsp_ce    = in_valid && !abort;
        opm_issue = first_q ? OPM_MUL : OPM_MAC;
        if (in_valid) begin
          dsp_a = a_in;
          dsp_b = b_in;
        end
      end
      StDrain: begin
        dsp_ce    = !abort;
        opm_issue = OPM_MAC;
      end
      default: ;
    endcase
  end

  dsp_opm_delay #(
    .Depth (OPM_DLY)
  ) u_opm_delay (
    .clk_i  (CLK),
    .rst_ni (RST),
    .en_i   (dsp_ce),
    .clr_i  (kill),
    .opm_i  (opm_issue),
    .opm_o  (dsp_opmode)
  );

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that sequences one DSP48A1-style slice (pre-adder/multiplier/post-adder with enable-gated pipeline registers) through an N-beat multiply-accumulate job.
- Accepts a job (start, len), streams operand pairs from a requester with a valid/ready handshake, and drives the slice's operands, OPMODE, clock enable and P-register reset.
- Signals done once the final accumulated P is settled and held. It sits between the stream source and the slice instance; it never sees P itself.

Parameters:
- A_W, 18, width of the A operand path.
- B_W, 18, width of the B operand path.
- LEN_W, 8, width of the job beat count.
- LAT, 4, number of enabled clock edges from operand issue until P holds that beat's contribution. Legal range 2..8.
- OPM_DLY, 1, number of enabled edges dsp_opmode is delayed so that it meets its beat at the post-adder. Legal range 0..LAT-1.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled in IDLE only.
- len  in  LEN_W  beat count; captured with start.
- abort  in  1  cancels the current job.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse; the slice P output is valid and held.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  the sequencer can accept a pair.
- a_in  in  A_W  A operand.
- b_in  in  B_W  B operand.
- dsp_a  out  A_W  slice A input.
- dsp_b  out  B_W  slice B input.
- dsp_opmode  out  8  slice OPMODE.
- dsp_ce  out  1  common clock enable for all slice pipeline registers.
- dsp_rstp  out  1  synchronous clear of the slice P register.

Behaviour:
- Reset (RST=0, asynchronous): state IDLE, counters 0, OPMODE delay line 0. All outputs are 0.
- States: IDLE, CLR, RUN, DRAIN, DONE.
- IDLE: in_ready=0, dsp_ce=0. On start=1:
  - len!=0: remaining<=len, first<=1, go to RUN.
  - len==0: go to CLR.
  - start has no effect in any state other than IDLE.
- CLR: dsp_rstp=1 for one cycle, then go to DONE. The job result is P=0.
- RUN:
  - in_ready=1 and dsp_ce=in_valid.
  - dsp_a/dsp_b = a_in/b_in when in_valid=1, otherwise 0.
  - Issue OPMODE = 8'h01 (X=multiplier, Z=0) for the first beat and 8'h09 (X=multiplier, Z=P) for each later beat.
  - On handshake: remaining decrements and first clears. The handshake on the last beat moves to DRAIN with drain_cnt<=LAT-1.
  - When in_valid=0 the slice is frozen (ce=0) and no state changes.
- DRAIN:
  - in_ready=0, dsp_ce=1, dsp_a=dsp_b=0, issue OPMODE 8'h09. These bubbles add 0 to P.
  - drain_cnt decrements each cycle; go to DONE when it reaches 0.
- DONE: done=1 and dsp_ce=0, so P is held. Go to IDLE next cycle.
- Outside RUN, CLR and DRAIN: dsp_a=dsp_b=0, issue OPMODE 8'h00, dsp_rstp=0.
- OPMODE delay: dsp_opmode is the issued OPMODE delayed by OPM_DLY shift stages. Each stage advances only when dsp_ce=1. OPM_DLY=0 means a combinational pass.
- Latency, for len=N, continuous in_valid, start sampled at edge 0:
  - RUN during cycles 1..N.
  - DRAIN during cycles N+1..N+LAT-1.
  - done during cycle N+LAT.
  - Each in_valid=0 cycle during RUN adds 1 cycle.
- abort=1 in any non-IDLE state:
  - Next state IDLE; done is not pulsed.
  - Counters and the OPMODE line are cleared.
  - dsp_ce=0 in the abort cycle.
  - abort has priority over all other transitions, including the last-beat handshake.
- A reset mid-job behaves like abort but is asynchronous. The slice P content is undefined afterwards and the next job overwrites it.
- Width rules: remaining is LEN_W bits; drain_cnt is clog2(LAT) bits. There is no arithmetic on operands.

Decomposition:
- Shared package dsp_seq_pkg holds:
  - the state enum (IDLE, CLR, RUN, DRAIN, DONE);
  - OPMODE constants OPM_IDLE=8'h00, OPM_MUL=8'h01, OPM_MAC=8'h09.
- Sub-module dsp_opm_delay: an OPM_DLY-deep, 8-bit shift register enabled by dsp_ce, with asynchronous active-low clear. It uses a generate bypass when OPM_DLY=0.

Test Plan:
- Behavioural slice model, LAT=4, OPM_DLY=1: len=3, pairs (2,3),(4,5),(-1,6) continuously valid -> in_ready high cycles 1-3, done at cycle 7, model P=20, busy low at cycle 8.
- Same job with in_valid low in cycles 2 and 3 -> dsp_ce=0 in those cycles, done at cycle 9, P=20.
- Back-to-back jobs: len=2 (7,7),(1,1) then len=1 (3,-4) -> first result 50, second result -12. The second job's first beat uses OPMODE 8'h01, so there is no carry-over.
- len=0 -> dsp_rstp=1 at cycle 1, done at cycle 2, model P=0. Also a start pulse while busy -> ignored, no second done.
- abort asserted during the last RUN beat handshake -> IDLE next cycle, done never pulses, busy low. A following len=1 (5,5) -> P=25.
- RST=0 mid-DRAIN, asynchronously between edges -> all outputs 0 immediately. After release, start len=1 (9,2) -> done at cycle 5, P=18.
